// File: rtl/ikaopm_timinggen_pkg.sv
// ---------------------------------------------------------------------------
// ikaopm_timing_pkg
// Shared timing constants and types for the OPM timing generator and the
// blocks that consume its slot counter.
//   SLOTS_DEFAULT : operator slots per frame
//   SLOT_W        : width of the slot counter for the default frame length
//   CYC_00/CYC_31 : slot numbers of the first and last slot of a frame
//   slot_t        : slot counter type for the default frame length
// ---------------------------------------------------------------------------
package ikaopm_timing_pkg;

    localparam int SLOTS_DEFAULT = 32;
    localparam int SLOT_W        = $clog2(SLOTS_DEFAULT);
    localparam int CYC_00        = 0;
    localparam int CYC_31        = 31;

    typedef logic [SLOT_W-1:0] slot_t;

endpackage

// File: rtl/ikaopm_timinggen_if.sv
// ---------------------------------------------------------------------------
// ikaopm_timinggen_if
// Bundle of timing outputs fanned out from the timing generator to the rest
// of the OPM core.
//   master : driven by ikaopm_timinggen
//   slave  : consumed by counters, delay lines and latches
// Signals: o_phi1_PCEN_n, o_phi1_NCEN_n, o_IC_n, o_SLOTCNTR, o_CYCLE_00,
//          o_CYCLE_31, o_SR_CNTRRST, o_FRAME_TICK and, when
//          IKAOPM_TIMINGGEN_DEBUG_EN is defined, o_DBG_FRAMECNTR.
// ---------------------------------------------------------------------------
interface ikaopm_timinggen_if
    import ikaopm_timing_pkg::*;
#(
    parameter int SLOT_W_P = SLOT_W
) ();

    logic                o_phi1_PCEN_n;
    logic                o_phi1_NCEN_n;
    logic                o_IC_n;
    logic [SLOT_W_P-1:0] o_SLOTCNTR;
    logic                o_CYCLE_00;
    logic                o_CYCLE_31;
    logic                o_SR_CNTRRST;
    logic                o_FRAME_TICK;
`ifdef IKAOPM_TIMINGGEN_DEBUG_EN
    logic [15:0]         o_DBG_FRAMECNTR;
`endif

    modport master (
        output o_phi1_PCEN_n, o_phi1_NCEN_n, o_IC_n, o_SLOTCNTR,
               o_CYCLE_00, o_CYCLE_31, o_SR_CNTRRST, o_FRAME_TICK
`ifdef IKAOPM_TIMINGGEN_DEBUG_EN
        , output o_DBG_FRAMECNTR
`endif
    );

    modport slave (
        input  o_phi1_PCEN_n, o_phi1_NCEN_n, o_IC_n, o_SLOTCNTR,
               o_CYCLE_00, o_CYCLE_31, o_SR_CNTRRST, o_FRAME_TICK
`ifdef IKAOPM_TIMINGGEN_DEBUG_EN
        , input o_DBG_FRAMECNTR
`endif
    );

endinterface

// File: rtl/ikaopm_timinggen_phi1_cengen.sv
// ---------------------------------------------------------------------------
// ikaopm_phi1_cengen
// Divides the phiM enable by two into phi1 and produces the phi1 rising and
// falling edge enables. Exactly one enable fires per phiM pulse.
//   i_EMUCLK       : master clock
//   i_RST_n        : synchronous active-low reset
//   i_phiM_PCEN_n  : active-low phiM enable, one EMUCLK wide
//   o_phi1_PCEN_n  : active-low phi1 rising-edge enable (combinational)
//   o_phi1_NCEN_n  : active-low phi1 falling-edge enable (combinational)
// ---------------------------------------------------------------------------
module ikaopm_phi1_cengen
    import ikaopm_timing_pkg::*;
(
    input  logic i_EMUCLK,
    input  logic i_RST_n,
    input  logic i_phiM_PCEN_n,
    output logic o_phi1_PCEN_n,
    output logic o_phi1_NCEN_n
);

    logic phi1_r;

    // phi1 toggles once per phiM enable
    always_ff @(posedge i_EMUCLK) begin
        if (!i_RST_n) begin
            phi1_r <= 1'b0;
        end else if (!i_phiM_PCEN_n) begin
            phi1_r <= ~phi1_r;
        end else begin
            phi1_r <= phi1_r;
        end
    end

    // Zero-latency enables: the phiM pulse that lifts phi1 is the rising
    // enable itself. Reset masks both so nothing downstream moves.
    assign o_phi1_PCEN_n = ~(i_RST_n & ~i_phiM_PCEN_n & ~phi1_r);
    assign o_phi1_NCEN_n = ~(i_RST_n & ~i_phiM_PCEN_n &  phi1_r);

endmodule

// File: rtl/ikaopm_timinggen.sv
// ---------------------------------------------------------------------------
// ikaopm_timinggen
// Upstream timing stage of the OPM core: phi1 enables, IC_n synchroniser,
// slot counter, per-frame realignment tick and slot decodes.
//   i_EMUCLK      : sole clock
//   i_RST_n       : synchronous active-low reset
//   i_phiM_PCEN_n : active-low phiM enable
//   i_IC_n        : external initial clear, active low, asynchronous level
//   tim           : timing output bundle (ikaopm_timinggen_if.master)
// Optional: define IKAOPM_TIMINGGEN_DEBUG_EN to add the 16-bit frame counter
// tim.o_DBG_FRAMECNTR.
// ---------------------------------------------------------------------------
module ikaopm_timinggen
    import ikaopm_timing_pkg::*;
#(
    parameter int SLOTS          = SLOTS_DEFAULT,
    parameter int IC_SYNC_STAGES = 2,
    parameter int CNTRRST_SLOT   = 31
)
(
    input  logic                i_EMUCLK,
    input  logic                i_RST_n,
    input  logic                i_phiM_PCEN_n,
    input  logic                i_IC_n,
    ikaopm_timinggen_if.master  tim
);

    localparam int            SW         = $clog2(SLOTS);
    localparam logic [SW-1:0] SLOT_LAST  = SW'(SLOTS - 1);
    localparam logic [SW-1:0] SLOT_FIRST = SW'(CYC_00);
    localparam logic [SW-1:0] SLOT_CRST  = SW'(CNTRRST_SLOT);

    logic                      phi1_pcen_n_s;
    logic                      phi1_ncen_n_s;
    logic                      pcen_s;
    logic                      ic_s;
    logic                      slot_last_s;
    logic [IC_SYNC_STAGES-1:0] ic_sync_r;
    logic [SW-1:0]             slot_r;
    logic                      frame_tick_r;

    ikaopm_phi1_cengen u_cengen (
        .i_EMUCLK      (i_EMUCLK),
        .i_RST_n       (i_RST_n),
        .i_phiM_PCEN_n (i_phiM_PCEN_n),
        .o_phi1_PCEN_n (phi1_pcen_n_s),
        .o_phi1_NCEN_n (phi1_ncen_n_s)
    );

    assign pcen_s      = ~phi1_pcen_n_s;
    assign ic_s        = ic_sync_r[IC_SYNC_STAGES-1];
    assign slot_last_s = (slot_r == SLOT_LAST);

    // IC_n synchroniser, advanced at the phi1 rate
    always_ff @(posedge i_EMUCLK) begin
        if (!i_RST_n) begin
            ic_sync_r <= {IC_SYNC_STAGES{1'b0}};
        end else if (pcen_s) begin
            ic_sync_r[0] <= i_IC_n;
            for (int i = 1; i < IC_SYNC_STAGES; i++) begin
                ic_sync_r[i] <= ic_sync_r[i-1];
            end
        end else begin
            ic_sync_r <= ic_sync_r;
        end
    end

    // Slot counter and frame tick; an IC-forced return to slot 0 is not a
    // wrap, so it never raises the tick
    always_ff @(posedge i_EMUCLK) begin
        if (!i_RST_n) begin
            slot_r       <= {SW{1'b0}};
            frame_tick_r <= 1'b0;
        end else if (pcen_s) begin
            if (!ic_s) begin
                slot_r       <= {SW{1'b0}};
                frame_tick_r <= 1'b0;
            end else if (slot_last_s) begin
                slot_r       <= {SW{1'b0}};
                frame_tick_r <= 1'b1;
            end else begin
                slot_r       <= slot_r + SW'(1);
                frame_tick_r <= 1'b0;
            end
        end else begin
            slot_r       <= slot_r;
            frame_tick_r <= frame_tick_r;
        end
    end

`ifdef IKAOPM_TIMINGGEN_DEBUG_EN
    logic [15:0] dbg_framecntr_r;

    // Frame counter: steps on the same edge the frame tick rises
    always_ff @(posedge i_EMUCLK) begin
        if (!i_RST_n) begin
            dbg_framecntr_r <= 16'd0;
        end else if (!ic_s) begin
            dbg_framecntr_r <= 16'd0;
        end else if (pcen_s && slot_last_s) begin
            dbg_framecntr_r <= dbg_framecntr_r + 16'd1;
        end else begin
            dbg_framecntr_r <= dbg_framecntr_r;
        end
    end

    assign tim.o_DBG_FRAMECNTR = dbg_framecntr_r;
`endif

    assign tim.o_phi1_PCEN_n = phi1_pcen_n_s;
    assign tim.o_phi1_NCEN_n = phi1_ncen_n_s;
    assign tim.o_IC_n        = ic_s;
    assign tim.o_SLOTCNTR    = slot_r;
    assign tim.o_FRAME_TICK  = frame_tick_r;
    // Decodes come straight off the registered counter, so they hold for a
    // whole phi1 period
    assign tim.o_CYCLE_00    = (slot_r == SLOT_FIRST);
    assign tim.o_CYCLE_31    = slot_last_s;
    assign tim.o_SR_CNTRRST  = (slot_r == SLOT_CRST) & ic_s;

endmodule
